// File: rtl/w_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the arbiter FSM state type, the default parameter values and
// the index-width helper used by the interface, the top and rr_pick.
package w_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_MAX_BURST = 4;

  // Width of each per-requester transfer counter slice.
  localparam int XFER_CNT_W = 16;

  // Burst counter width; covers 0..15, enough for MAX_BURST up to 16.
  localparam int BURST_CNT_W = 4;

  // Bits needed to hold a requester index (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/w_port_arbiter_if.sv
// Bus bundle between the requesters/FIFO and the write-port arbiter.
//
// Handshake: req[i] acts as requester i's valid and must stay high until
// the requester has been served. A beat from requester i is taken in
// any cycle where gnt[i]=1 and w_en=1. w_en is (owner request & !w_full),
// so w_full acts as the FIFO's inverted ready. w_full never revokes a
// grant by itself.
// The dbg_* signals expose arbiter FSM state for observation only.
interface w_port_arbiter_if #(
  parameter int NUM_REQ   = w_arb_pkg::DEF_NUM_REQ,
  parameter int DATA_SIZE = w_arb_pkg::DEF_DATA_SIZE
);
  import w_arb_pkg::*;

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_SIZE-1:0]  req_data;
  logic                          w_full;
  logic [NUM_REQ-1:0]            gnt;
  logic                          w_en;
  logic [DATA_SIZE-1:0]          w_data;
  logic [NUM_REQ*XFER_CNT_W-1:0] xfer_cnt;

  arb_state_e                    dbg_state;
  logic [BURST_CNT_W-1:0]        dbg_burst_cnt;
  logic [IDX_W-1:0]              dbg_last_owner;

  // Arbiter side.
  modport master (
    input  req, req_data, w_full,
    output gnt, w_en, w_data, xfer_cnt,
    output dbg_state, dbg_burst_cnt, dbg_last_owner
  );

  // Requester / FIFO side.
  modport slave (
    output req, req_data, w_full,
    input  gnt, w_en, w_data, xfer_cnt,
    input  dbg_state, dbg_burst_cnt, dbg_last_owner
  );

endinterface

// File: rtl/w_port_arbiter_rr_pick.sv
// Round-robin search: returns the first set bit of req_i found when
// scanning upward from start_i and wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = w_arb_pkg::DEF_NUM_REQ,
  parameter int IDX_W   = w_arb_pkg::idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the farthest offset down so the nearest candidate wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(start_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/w_port_arbiter.sv
// FIFO write-port arbiter: NUM_REQ requesters share one FIFO write side.
// Grants are round-robin, each grant lasts up to MAX_BURST transfers,
// and w_full stalls a burst without ending it.
// Optional feature: define W_PORT_ARBITER_STATS_EN to build saturating
// 16-bit per-requester transfer counters on xfer_cnt; otherwise xfer_cnt
// is tied to zero and no counter registers exist.
module w_port_arbiter
  import w_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic              w_clk,
  input logic              wrst,
  w_port_arbiter_if.master bus
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [DATA_SIZE-1:0]   slot_data [NUM_REQ];
  logic                   owner_req;
  logic                   xfer;
  logic                   burst_end;
  logic [NUM_REQ-1:0]     owner_mask;
  logic [NUM_REQ-1:0]     pick_req;
  logic [IDX_W-1:0]       pick_start;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  // Next index after i, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot_data[g] = bus.req_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // A transfer needs a live owner request and FIFO room; reset blocks it.
  assign owner_req  = bus.req[owner_q];
  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign xfer       = (state_q == BURST) & owner_req & ~bus.w_full & ~wrst;
  assign burst_end  = (state_q == BURST) &
                      ((xfer & (burst_cnt_q == LAST_BEAT)) | ~owner_req);

  // One search serves both cases: from IDLE it scans every request after
  // last_owner; at burst end it scans the other requesters after owner.
  assign pick_req   = (state_q == IDLE) ? bus.req : (bus.req & ~owner_mask);
  assign pick_start = (state_q == IDLE) ? wrap_inc(last_owner_q) : wrap_inc(owner_q);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign bus.gnt            = gnt_q;
  assign bus.w_en           = xfer;
  assign bus.w_data         = (|gnt_q) ? slot_data[owner_q] : '0;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_burst_cnt  = burst_cnt_q;
  assign bus.dbg_last_owner = last_owner_q;

  // Next-state logic: grant selection, burst counting and burst hand-off.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BURST;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
        end
      end
      BURST: begin
        if (burst_end) begin
          burst_cnt_d  = '0;
          last_owner_d = owner_q;
          if (pick_valid) begin
            owner_d = pick_idx;
            gnt_d   = NUM_REQ'(1) << pick_idx;
          end else if (!owner_req) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (xfer && (burst_cnt_q != LAST_BEAT)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // FSM and grant registers with synchronous reset.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      last_owner_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef W_PORT_ARBITER_STATS_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q [NUM_REQ];

  // Saturating per-requester count of transfers.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        xfer_cnt_q[i] <= '0;
      end
    end else if (xfer && (xfer_cnt_q[owner_q] != '1)) begin
      xfer_cnt_q[owner_q] <= xfer_cnt_q[owner_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign bus.xfer_cnt[g*XFER_CNT_W +: XFER_CNT_W] = xfer_cnt_q[g];
  end
`else
  assign bus.xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_w_port_arbiter.sv
// Testbench for w_port_arbiter: reset checks, a hand-computed vector
// table, directed multi-cycle sequences, and randomized traffic checked
// against a behavioural model of the arbitration rules.
module tb_w_port_arbiter;
  import w_arb_pkg::*;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int MB = 4;
  localparam logic [N*D-1:0] TDATA = 32'hA3A2_A1A0;

  // ---------------- clock / reset ----------------
  logic w_clk = 1'b0;
  logic wrst  = 1'b1;
  always #5 w_clk = ~w_clk;

  w_port_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(D)) bus ();

  w_port_arbiter #(
    .NUM_REQ   (N),
    .DATA_SIZE (D),
    .MAX_BURST (MB)
  ) dut (
    .w_clk (w_clk),
    .wrst  (wrst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  int m_owner;     // -1 when nobody holds the port
  int m_cnt;       // transfers done in the current burst
  int m_last;      // requester whose burst ended most recently
  int m_stats [N];

  function automatic int rr_first(input logic [N-1:0] mask, input int from);
    for (int k = 0; k < N; k++) begin
      if (mask[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic model_wen();
    if (m_owner < 0) return 1'b0;
    return bus.req[m_owner] && !bus.w_full && !wrst;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [D-1:0] model_wdata();
    if (m_owner < 0) return '0;
    return bus.req_data[m_owner*D +: D];
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    logic [N-1:0] rq;
    logic [N-1:0] others;
    logic         wen;
    rq = bus.req;
    if (wrst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_stats[i] = 0;
      return;
    end
    wen = model_wen();
    if (m_owner < 0) begin
      if (rq != '0) m_owner = rr_first(rq, (m_last + 1) % N);
    end else begin
      if (wen && m_stats[m_owner] < 65535) m_stats[m_owner]++;
      if ((wen && m_cnt == MB - 1) || !rq[m_owner]) begin
        m_last = m_owner;
        m_cnt  = 0;
        others = rq;
        others[m_owner] = 1'b0;
        if (others != '0) m_owner = rr_first(others, (m_owner + 1) % N);
        else if (!rq[m_owner]) m_owner = -1;
      end else if (wen) begin
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs just after a rising edge and move to the sampling point.
  task automatic set_in(input logic [N-1:0] r, input logic [N*D-1:0] d,
                        input logic f, input logic rs);
    bus.req      = r;
    bus.req_data = d;
    bus.w_full   = f;
    wrst         = rs;
    @(negedge w_clk);
  endtask

  task automatic tick();
    @(posedge w_clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    set_in('0, TDATA, 1'b0, 1'b1);
    tick();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_cnt;
    chk("gnt", 32'(bus.gnt), 32'(model_gnt()));
    chk("w_en", 32'(bus.w_en), 32'(model_wen()));
    chk("w_data", 32'(bus.w_data), 32'(model_wdata()));
    chk("state", 32'(bus.dbg_state), (m_owner < 0) ? 32'(IDLE) : 32'(BURST));
    chk("burst_cnt", 32'(bus.dbg_burst_cnt), 32'(m_cnt));
    chk("last_owner", 32'(bus.dbg_last_owner), 32'(m_last));
    for (int i = 0; i < N; i++) begin
`ifdef W_PORT_ARBITER_STATS_EN
      exp_cnt = 32'(m_stats[i]);
`else
      exp_cnt = 32'd0;
`endif
      chk("xfer_cnt", 32'(bus.xfer_cnt[i*16 +: 16]), exp_cnt);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] rq;
    logic         fl;
    logic         rs;
    logic [N-1:0] e_gnt;
    logic         e_wen;
    logic [D-1:0] e_wdata;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] eg;

    // Sequence: single requester burst and re-grant, hand-off on request
    // drop, w_full stall, reset mid-burst, return to IDLE.
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[2]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0};
    tbl[3]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0};
    tbl[4]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0};
    tbl[5]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA0};
    tbl[6]  = '{4'b1010, 1'b0, 1'b0, 4'b0001, 1'b0, 8'hA0};
    tbl[7]  = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hA1};
    tbl[8]  = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 8'hA1};
    tbl[9]  = '{4'b1000, 1'b0, 1'b0, 4'b0010, 1'b0, 8'hA1};
    tbl[10] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 8'hA3};
    tbl[11] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 8'hA3};
    tbl[12] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 8'hA3};
    tbl[13] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0, 8'hA3};
    tbl[14] = '{4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 8'hA3};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00};

    bus.req      = '0;
    bus.req_data = TDATA;
    bus.w_full   = 1'b0;
    wrst         = 1'b1;
    tick();
    tick();

    // Reset state.
    set_in('0, TDATA, 1'b0, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_w_en", 32'(bus.w_en), 32'd0);
    chk("rst_w_data", 32'(bus.w_data), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst_burst_cnt", 32'(bus.dbg_burst_cnt), 32'd0);
    chk("rst_last_owner", 32'(bus.dbg_last_owner), 32'd3);
    chk("rst_xfer_cnt", bus.xfer_cnt[31:0], 32'd0);
    tick();

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].rq, TDATA, tbl[i].fl, tbl[i].rs);
      chk($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_w_en", i), 32'(bus.w_en), 32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_w_data", i), 32'(bus.w_data), 32'(tbl[i].e_wdata));
      tick();
    end

    // All four requesting: 0,1,2,3,0 with four beats each, no gaps.
    reset_dut();
    set_in(4'b1111, TDATA, 1'b0, 1'b0);
    chk("rr_idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    for (int k = 0; k < 20; k++) begin
      set_in(4'b1111, TDATA, 1'b0, 1'b0);
      eg = '0;
      eg[(k / 4) % N] = 1'b1;
      chk("rr_gnt", 32'(bus.gnt), 32'(eg));
      chk("rr_w_en", 32'(bus.w_en), 32'd1);
      tick();
    end

    // Owner 2 stalled by w_full for five cycles after two beats.
    reset_dut();
    set_in(4'b0100, TDATA, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(4'b0100, TDATA, 1'b0, 1'b0);
      chk("stall_pre_gnt", 32'(bus.gnt), 32'b0100);
      chk("stall_pre_w_en", 32'(bus.w_en), 32'd1);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      set_in(4'b0100, TDATA, 1'b1, 1'b0);
      chk("stall_gnt", 32'(bus.gnt), 32'b0100);
      chk("stall_w_en", 32'(bus.w_en), 32'd0);
      chk("stall_burst_cnt", 32'(bus.dbg_burst_cnt), 32'd2);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      set_in(4'b0100, TDATA, 1'b0, 1'b0);
      chk("stall_post_w_en", 32'(bus.w_en), 32'd1);
      chk("stall_post_burst_cnt", 32'(bus.dbg_burst_cnt), 32'(2 + k));
      chk("stall_post_w_data", 32'(bus.w_data), 32'hA2);
      tick();
    end
    set_in(4'b0100, TDATA, 1'b0, 1'b0);
    chk("stall_regrant_gnt", 32'(bus.gnt), 32'b0100);
    chk("stall_regrant_burst_cnt", 32'(bus.dbg_burst_cnt), 32'd0);
    tick();

    // Randomized traffic against the model.
    reset_dut();
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if ($urandom_range(0, 7) == 0) r[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          r[i] = 1'b1;
        end
      end
      set_in(r, $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      check_model();
      tick();
    end

`ifdef W_PORT_ARBITER_STATS_EN
    // Long single-requester run saturates its counter.
    reset_dut();
    set_in(4'b0001, TDATA, 1'b0, 1'b0);
    chk("sat_start_cnt", bus.xfer_cnt[31:0], 32'd0);
    repeat (66000) @(posedge w_clk);
    @(negedge w_clk);
    chk("sat_cnt0", 32'(bus.xfer_cnt[15:0]), 32'hFFFF);
    chk("sat_cnt_others", 32'(bus.xfer_cnt[63:16]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/w_port_arbiter.md
W_PORT_ARBITER -- requirements
Module: w_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DATA_SIZE, default 8, SHALL set the FIFO write-data width.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum transfers per grant (1..16).
REQ-004 One clock and a synchronous, active-high reset are already decided; ports SHALL follow REQ-005 and REQ-006.
REQ-005 w_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 wrst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 req  input  NUM_REQ  SHALL carry per-requester write requests, held until served.
REQ-008 req_data  input  NUM_REQ*DATA_SIZE  SHALL carry flattened per-requester data; slice i = [i*DATA_SIZE +: DATA_SIZE].
REQ-009 w_full  input  1  SHALL be the registered full flag from the FIFO write side.
REQ-010 gnt  output  NUM_REQ  SHALL be a one-hot or zero registered grant vector.
REQ-011 w_en  output  1  SHALL be the FIFO write enable.
REQ-012 w_data  output  DATA_SIZE  SHALL be the FIFO write data.
REQ-013 xfer_cnt  output  NUM_REQ*16  SHALL carry per-requester transfer counts (see Configuration).

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and BURST (owner = index of the set gnt bit).
REQ-015 In IDLE with any req bit set, the next state SHALL be BURST, with owner chosen round-robin starting at last_owner+1 (mod NUM_REQ).
REQ-016 Grant latency SHALL be one cycle: a req first seen in IDLE at edge N asserts gnt at edge N+1.
REQ-017 In BURST, w_en SHALL equal req[owner] & !w_full, combinationally.
REQ-018 w_data SHALL equal the owner's req_data slice whenever gnt is non-zero; otherwise it SHALL be 0.
REQ-019 A transfer SHALL be any cycle with w_en=1; burst_cnt SHALL then increment and saturate at MAX_BURST-1.
REQ-020 BURST SHALL end when a transfer occurs with burst_cnt=MAX_BURST-1, or when req[owner]=0.
REQ-021 At burst end, if any other req bit is set, the grant SHALL move directly, next cycle, to the next round-robin requester after the owner; otherwise to the owner again if req[owner]=1; else the FSM SHALL go to IDLE.
REQ-022 At every burst end, burst_cnt SHALL clear and last_owner SHALL update to the ending owner.
REQ-023 While w_full=1, w_en SHALL be 0, burst_cnt SHALL hold and the grant SHALL hold; w_full alone SHALL never end a burst.
REQ-024 gnt SHALL never have more than one bit set, and w_en SHALL never be 1 without a grant.

Reset
REQ-025 On wrst=1 at a clock edge: state=IDLE, gnt=0, burst_cnt=0, last_owner=NUM_REQ-1 (so requester 0 has first priority), all xfer_cnt=0.
REQ-026 Reset asserted mid-burst SHALL drop gnt and w_en in the same cycle the registered outputs update; no transfer SHALL be counted in that cycle.
REQ-027 During reset, w_en SHALL be 0 regardless of req.

Configuration
REQ-028 Macro W_PORT_ARBITER_STATS_EN defined: each 16-bit xfer_cnt slice SHALL increment on its requester's transfers and saturate at 0xFFFF.
REQ-029 Macro undefined: xfer_cnt SHALL be tied to 0 with no counter registers; all other behaviour is identical.

Structure
REQ-030 Package w_arb_pkg SHALL hold the FSM state typedef (IDLE, BURST) and the default parameter constants.
REQ-031 The round-robin search SHALL be one sub-module, rr_pick (inputs: req vector, start index; outputs: valid, index), instantiated once.

Verification
REQ-032 After reset, req=4'b0001: gnt=0001 one cycle later; 4 transfers with w_en=1; then gnt=0001 retained while req[0] stays high.
REQ-033 req=4'b1111 held, w_full=0: grant order 0,1,2,3,0, each burst exactly 4 w_en cycles, no idle cycle between bursts.
REQ-034 Owner 2 granted and w_full=1 for 5 cycles mid-burst: w_en=0, gnt and burst_cnt frozen; the burst resumes and completes 4 transfers after w_full=0.
REQ-035 req[1] drops after 2 transfers with req[3] pending: next cycle gnt=1000, and w_data tracks req_data slice 3.
REQ-036 wrst pulsed mid-burst: next cycle gnt=0, w_en=0, state IDLE; with STATS_EN, all xfer_cnt=0 and 70000 transfers on requester 0 give xfer_cnt[15:0]=0xFFFF.
